// File: rtl/tiny_alu_seq.sv
// tiny_alu_seq: bit-serial AND/OR/XOR sequencer, one result bit per clock, LSB first.
// Optional reserved-opcode flag output op_err is enabled by defining TINY_ALU_SEQ_OPERR_EN.
`default_nettype none

module tiny_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
`ifdef TINY_ALU_SEQ_OPERR_EN
  output logic             op_err,
`endif
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] y_q;
  logic             alu_bit;

  // The single shared 1-bit ALU; the reserved opcode produces 0.
  always_comb begin
    alu_bit = 1'b0;
    case (op_q)
      2'b00:   alu_bit = a_q[cnt_q] & b_q[cnt_q];
      2'b01:   alu_bit = a_q[cnt_q] | b_q[cnt_q];
      2'b10:   alu_bit = a_q[cnt_q] ^ b_q[cnt_q];
      default: alu_bit = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= in_a;
            b_q   <= in_b;
            op_q  <= in_op;
            cnt_q <= '0;
          end
        end
        RUN: begin
          y_q[cnt_q] <= alu_bit;
          cnt_q      <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_y = y_q;

`ifdef TINY_ALU_SEQ_OPERR_EN
  logic op_err_q;

  // Flag raised at capture of a reserved opcode, held until its result is taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_err_q <= 1'b0;
    end else if (state_q == IDLE && in_valid) begin
      op_err_q <= (in_op == 2'b11);
    end else if (state_q == DONE && out_ready) begin
      op_err_q <= 1'b0;
    end
  end

  assign op_err = op_err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tiny_alu_seq.sv
// Self-checking bench for tiny_alu_seq (WIDTH=8) with a word-level reference model.
`timescale 1ns/1ps

module tb_tiny_alu_seq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             busy;
`ifdef TINY_ALU_SEQ_OPERR_EN
  logic             op_err;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  tiny_alu_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
`ifdef TINY_ALU_SEQ_OPERR_EN
    .op_err    (op_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout time=%0t required finish", $time);
    $fatal(1, "global timeout");
  end

  // Whole-word reference: the serial datapath must equal these word operations.
  function automatic logic [WIDTH-1:0] ref_y(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Issues one command and consumes its result after 'stall' cycles of backpressure.
  task automatic do_command(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [1:0] op, input int stall);
    logic [WIDTH-1:0] exp;
    int n;
    exp = ref_y(a, b, op);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
      in_valid = 1'b0; return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = WIDTH'($urandom); in_b = WIDTH'($urandom); in_op = 2'($urandom);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL run_flags in_ready=%b busy=%b required 0/1", in_ready, busy);
      end
      @(posedge clk); #1; n++;
    end
    out_ready = (stall == 0);
    // Value visible n edges after the accept edge belongs to cycle T0+n+1.
    checks++;
    if (n + 1 !== WIDTH + 1) begin
      errors++; $display("FAIL latency cycle=T0+%0d required T0+%0d", n + 1, WIDTH + 1);
    end
    checks++;
    if (out_y !== exp || in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL result out_y=%h in_ready=%b busy=%b required %h/0/1", out_y, in_ready, busy, exp);
    end
`ifdef TINY_ALU_SEQ_OPERR_EN
    checks++;
    if (op_err !== (op == 2'b11)) begin
      errors++; $display("FAIL op_err_done op_err=%b required %b", op_err, op == 2'b11);
    end
`endif
    in_valid = 1'b1; in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if (i == stall - 1) out_ready = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || out_y !== exp || in_ready !== 1'b0) begin
        errors++; $display("FAIL stall_hold out_valid=%b out_y=%h in_ready=%b required 1/%h/0", out_valid, out_y, in_ready, exp);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_y !== exp) begin
      errors++; $display("FAIL after_handshake out_valid=%b in_ready=%b busy=%b out_y=%h required 0/1/0/%h", out_valid, in_ready, busy, out_y, exp);
    end
`ifdef TINY_ALU_SEQ_OPERR_EN
    checks++;
    if (op_err !== 1'b0) begin
      errors++; $display("FAIL op_err_clear op_err=%b required 0", op_err);
    end
`endif
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_y !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_state out_valid=%b out_y=%h busy=%b required 0/00/0", out_valid, out_y, busy);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || out_y !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL idle_after_reset cycle=%0d out_valid=%b out_y=%h busy=%b in_ready=%b required 0/00/0/1", i, out_valid, out_y, busy, in_ready);
      end
    end
  endtask

  task automatic test_and;
    do_command(8'hF0, 8'hCC, 2'b00, 0);
  endtask

  task automatic test_back_to_back;
    logic [WIDTH-1:0] got [2];
    int ng, t1, t2, n;
    bit pending, sent2;
    ng = 0; t2 = 0; n = 0; pending = 0; sent2 = 0;
    out_ready = 1'b1;
    in_a = 8'h0F; in_b = 8'h30; in_op = 2'b01; in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    t1 = cyc;
    in_a = 8'hAA; in_b = 8'hFF; in_op = 2'b10;
    n = 0;
    while (ng < 2 && n < 60) begin
      @(posedge clk); #1; n++;
      if (out_valid === 1'b1) begin got[ng] = out_y; ng++; end
      if (pending) begin in_valid = 1'b0; t2 = cyc; pending = 0; sent2 = 1; end
      else if (!sent2 && in_ready === 1'b1) pending = 1;
    end
    in_valid = 1'b0;
    checks++;
    if (ng != 2) begin
      errors++; $display("FAIL b2b_count results=%0d required 2", ng);
    end else begin
      checks++;
      if (got[0] !== ref_y(8'h0F, 8'h30, 2'b01) || got[1] !== ref_y(8'hAA, 8'hFF, 2'b10)) begin
        errors++; $display("FAIL b2b_results got=%h,%h required 3f,55", got[0], got[1]);
      end
    end
    checks++;
    if (!sent2 || t2 - t1 < WIDTH + 2) begin
      errors++; $display("FAIL b2b_spacing spacing=%0d required >=%0d", t2 - t1, WIDTH + 2);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    do_command(8'h5A, 8'h5A, 2'b10, 5);
  endtask

  task automatic test_op11;
    do_command(8'hFF, 8'hFF, 2'b11, 2);
  endtask

  task automatic test_reset_abort;
    int n;
    in_a = 8'hFF; in_b = 8'hFF; in_op = 2'b01; in_valid = 1'b1; out_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL abort_state out_valid=%b busy=%b in_ready=%b required 0/0/1", out_valid, busy, in_ready);
    end
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL abort_no_result cycle=%0d out_valid=%b required 0", i, out_valid);
      end
    end
    do_command(8'h81, 8'h01, 2'b01, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 16; i++) begin
      do_command(WIDTH'($urandom), WIDTH'($urandom), 2'($urandom_range(0, 3)), $urandom_range(0, 3));
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
    test_reset();
    test_and();
    test_back_to_back();
    test_backpressure();
    test_op11();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
